serv_csr_mirq: RTL and testbench
================================

Name: serv_csr_mirq

Overview:
- Parametrised bit-serial machine-mode CSR and interrupt unit for the SERV core; next generation of the core's CSR block.
- Supports W=1 or W=4 datapath slices and NIRQ platform-local interrupt lines (mie/mip bits 16+) alongside timer (MTI) and external (MEI) interrupts.
- Makes mstatus.MPIE, mie and mip software-visible; performs fixed-priority interrupt selection with a 5-bit mcause code.
- mscratch/mtvec/mepc remain in the register file and arrive via i_rf_csr_out.

Parameters:
- W, 1, serial slice width in bits; legal values 1 and 4.
- NIRQ, 4, number of local interrupt lines; range 0..16.
- RESET_STRATEGY, "MINI", "MINI" resets all state listed below; "NONE" resets nothing.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset: i_rst, synchronous, active-high; clock i_clk
- i_cnt  in  5  bit index of the LSB of the current slice; steps by W, 0..32-W
- i_en  in  1  slice valid (serial execute phase)
- i_cnt_done  in  1  last slice of the instruction
- i_trig_irq  in  1  instruction-boundary interrupt sample strobe
- i_mtip  in  1  timer interrupt level
- i_meip  in  1  external interrupt level
- i_lirq  in  max(NIRQ,1)  local interrupt levels
- o_new_irq  out  1  interrupt accepted; core must trap
- i_trap  in  1  trap in progress
- i_mret  in  1  mret executing
- i_e_op  in  1  ecall/ebreak
- i_ebreak  in  1  ebreak
- i_mem_op  in  1  misaligned load/store
- i_mem_cmd  in  1  1 = store
- i_csr_sel  in  4  one-hot select {mcause, mip, mie, mstatus}
- i_csr_source  in  2  00 CSR, 01 EXT, 10 SET, 11 CLR
- i_csr_d_sel  in  1  1 = immediate operand
- i_csr_imm  in  W  immediate slice
- i_rs1  in  W  rs1 slice
- i_rf_csr_out  in  W  register-file CSR slice
- o_csr_in  out  W  new CSR value slice
- o_q  out  W  CSR read slice

Behaviour:
- d = i_csr_d_sel ? imm : rs1.
- csr_in:
  - EXT = d
  - SET = csr_out|d
  - CLR = csr_out&~d
  - CSR = csr_out
- csr_out = OR of selected register slice (gated by i_en) and i_rf_csr_out. o_q = csr_out; o_csr_in = csr_in.
- Bit b of a register is visible/written in the slice where i_cnt == b-(b%W), lane b%W. Unimplemented bits read 0 and ignore writes.
- mstatus: bit 3 MIE, bit 7 MPIE; bits 11,12 (MPP) read 1.
- mie: bit 7 MTIE, bit 11 MEIE, bits 16+k LIE[k].
- mip: bit 7 = i_mtip, bit 11 = i_meip, bits 16+k = local pending; read-only unless LATCH (see Optional Feature).
- mcause: bits 4:0 code, bit 31 interrupt flag; software-writable.
- Pending/enabled set P = mip & mie. Priority: MEI(11) > MTI(7) > LIRQ lowest k (16+k).
- On i_trig_irq:
  - o_new_irq <= mstatus.MIE & |P.
  - irq_code <= highest-priority code.
  - Both use register values from before any same-cycle write.
- o_new_irq holds until the next i_trig_irq, or until the cycle after i_trap&i_cnt_done, which clears it.
- Trap completion (i_trap&i_cnt_done):
  - MPIE <= MIE; MIE <= 0; mcause31 <= o_new_irq.
  - code <= o_new_irq ? irq_code : exception code.
  - Exception codes: ebreak 3, ecall 11, misaligned load 4, misaligned store 6, misaligned jump 0.
- mret (at i_cnt_done): MIE <= MPIE; MPIE <= 1.
- Trap completion overrides any CSR write to mstatus/mcause in the same cycle.
- i_en=0: no CSR register changes; trap/mret/trig still act.
- Reset (MINI):
  - o_new_irq=0, MIE=0, MPIE=0, mie=0, mcause=0, irq_code=0, latched pending=0.
  - Reset mid-instruction aborts any partial serial write.
  - Reset overrides all same-cycle updates.
- NIRQ=0: i_lirq ignored; bits 16+ read 0.

Optional Feature:
- Macro SERV_CSR_LIRQ_LATCH_EN.
- Defined: each local pending bit sets on a rising edge of i_lirq[k] (one flop delay) and stays set. Software clears it via a CLR/EXT write of 0 to mip bit 16+k. If set and clear coincide, set wins.
- Undefined: local pending = i_lirq level; mip fully read-only.

Test Plan:
- W=1, reset, i_cnt 0..31 read of mstatus -> o_q 1 only at bits 11,12; mie reads all 0; o_new_irq=0.
- csrrs mie with rs1=0x800, mstatus MIE=1, i_meip=1 and i_mtip=1, pulse i_trig_irq -> o_new_irq=1. Then trap -> mcause=0x8000000B, MIE=0, MPIE=1.
- W=4, NIRQ=4, mie=0x000A0000, i_lirq=4'b1010 (no MEI/MTI), trig+trap -> mcause=0x80000011. A following mret -> MIE=1, MPIE=1.
- ecall trap with o_new_irq=0 -> mcause=0x0000000B. Store misaligned (i_mem_op=1, i_mem_cmd=1) -> 0x00000006.
- LATCH build: pulse i_lirq[0] one cycle -> mip bit16=1 persists. csrrc mip rs1=0x10000 -> bit16=0. Edge in the same cycle as the clear -> bit16 stays 1.
- i_rst asserted in mid-serial write to mie at i_cnt=8 (W=1) -> mie=0 after reset; MEIE not set.

Source files
------------

// File: rtl/serv_csr_mirq.sv
// Bit-serial machine-mode CSR and interrupt unit (mstatus/mie/mip/mcause) for SERV.
// Optional sticky edge-latched local interrupts: define SERV_CSR_LIRQ_LATCH_EN.
module serv_csr_mirq #(
  parameter int W              = 1,
  parameter int NIRQ           = 4,
  parameter     RESET_STRATEGY = "MINI"
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [4:0]                          i_cnt,
  input  logic                                i_en,
  input  logic                                i_cnt_done,
  input  logic                                i_trig_irq,
  input  logic                                i_mtip,
  input  logic                                i_meip,
  input  logic [((NIRQ > 0) ? NIRQ : 1)-1:0] i_lirq,
  output logic                                o_new_irq,
  input  logic                                i_trap,
  input  logic                                i_mret,
  input  logic                                i_e_op,
  input  logic                                i_ebreak,
  input  logic                                i_mem_op,
  input  logic                                i_mem_cmd,
  input  logic [3:0]                          i_csr_sel,
  input  logic [1:0]                          i_csr_source,
  input  logic                                i_csr_d_sel,
  input  logic [W-1:0]                        i_csr_imm,
  input  logic [W-1:0]                        i_rs1,
  input  logic [W-1:0]                        i_rf_csr_out,
  output logic [W-1:0]                        o_csr_in,
  output logic [W-1:0]                        o_q
);
  localparam int LW     = (NIRQ > 0) ? NIRQ : 1;
  localparam bit RST_EN = (RESET_STRATEGY != "NONE");

  logic          mstatus_mie, mstatus_mpie;
  logic          mie_mtie, mie_meie;
  logic [LW-1:0] mie_lie, lirq_pend, p_loc;
  logic [4:0]    mcause_code, irq_code, irq_code_nxt, exc_code;
  logic          mcause_int, new_irq;
  logic [31:0]   mstatus_v, mie_v, mip_v, mcause_v, sel_v;
  logic [W-1:0]  d, reg_slice, csr_out, csr_in;
  logic          wr_mstatus, wr_mie, wr_mcause, trap_done, mret_done;
  logic          p_mti, p_mei, irq_any;

  // True when register bit b lives in the slice currently on the bus.
  function automatic logic slot(input logic [4:0] cnt, input int unsigned b);
    return cnt == 5'(b - (b % W));
  endfunction

  always_comb begin
    mstatus_v        = '0;
    mstatus_v[3]     = mstatus_mie;
    mstatus_v[7]     = mstatus_mpie;
    mstatus_v[12:11] = 2'b11;
    mie_v            = '0;
    mie_v[7]         = mie_mtie;
    mie_v[11]        = mie_meie;
    mip_v            = '0;
    mip_v[7]         = i_mtip;
    mip_v[11]        = i_meip;
    for (int unsigned k = 0; k < NIRQ; k++) begin
      mie_v[16+k] = mie_lie[k];
      mip_v[16+k] = lirq_pend[k];
    end
    mcause_v         = '0;
    mcause_v[31]     = mcause_int;
    mcause_v[4:0]    = mcause_code;
  end

  always_comb begin
    p_mti   = i_mtip & mie_mtie;
    p_mei   = i_meip & mie_meie;
    p_loc   = lirq_pend & mie_lie;
    irq_any = p_mti | p_mei;
    irq_code_nxt = '0;
    for (int unsigned k = 0; k < NIRQ; k++) begin
      irq_any = irq_any | p_loc[NIRQ-1-k];
      if (p_loc[NIRQ-1-k]) irq_code_nxt = 5'(16 + NIRQ - 1 - k);
    end
    if (p_mti) irq_code_nxt = 5'd7;
    if (p_mei) irq_code_nxt = 5'd11;
  end

  always_comb begin
    exc_code = 5'd0;
    if (i_e_op)        exc_code = i_ebreak  ? 5'd3 : 5'd11;
    else if (i_mem_op) exc_code = i_mem_cmd ? 5'd6 : 5'd4;
  end

  always_comb begin
    sel_v = ({32{i_csr_sel[0]}} & mstatus_v) | ({32{i_csr_sel[1]}} & mie_v) |
            ({32{i_csr_sel[2]}} & mip_v)     | ({32{i_csr_sel[3]}} & mcause_v);
    reg_slice = '0;
    for (int unsigned l = 0; l < W; l++)
      reg_slice[l] = i_en & sel_v[5'(i_cnt + 5'(l))];
    csr_out = reg_slice | i_rf_csr_out;
    d       = i_csr_d_sel ? i_csr_imm : i_rs1;
    case (i_csr_source)
      2'b01:   csr_in = d;
      2'b10:   csr_in = csr_out | d;
      2'b11:   csr_in = csr_out & ~d;
      default: csr_in = csr_out;
    endcase
  end

  assign o_q        = csr_out;
  assign o_csr_in   = csr_in;
  assign o_new_irq  = new_irq;
  assign wr_mstatus = i_en & i_csr_sel[0];
  assign wr_mie     = i_en & i_csr_sel[1];
  assign wr_mcause  = i_en & i_csr_sel[3];
  assign trap_done  = i_trap & i_cnt_done;
  assign mret_done  = i_mret & i_cnt_done;

  // Later assignments take priority: CSR write < trig < trap < mret < reset.
  always_ff @(posedge i_clk) begin
    if (wr_mstatus && slot(i_cnt, 3)) mstatus_mie  <= csr_in[3 % W];
    if (wr_mstatus && slot(i_cnt, 7)) mstatus_mpie <= csr_in[7 % W];
    if (wr_mie && slot(i_cnt, 7))     mie_mtie     <= csr_in[7 % W];
    if (wr_mie && slot(i_cnt, 11))    mie_meie     <= csr_in[11 % W];
    for (int unsigned k = 0; k < NIRQ; k++)
      if (wr_mie && slot(i_cnt, 16 + k)) mie_lie[k] <= csr_in[(16 + k) % W];
    for (int unsigned b = 0; b < 5; b++)
      if (wr_mcause && slot(i_cnt, b)) mcause_code[b] <= csr_in[b % W];
    if (wr_mcause && slot(i_cnt, 31)) mcause_int <= csr_in[31 % W];

    if (i_trig_irq) begin
      new_irq  <= mstatus_mie & irq_any;
      irq_code <= irq_code_nxt;
    end
    if (trap_done) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
      mcause_int   <= new_irq;
      mcause_code  <= new_irq ? irq_code : exc_code;
      new_irq      <= 1'b0;
    end
    if (mret_done) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end

    if (RST_EN && i_rst) begin
      new_irq      <= 1'b0;
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_mtie     <= 1'b0;
      mie_meie     <= 1'b0;
      mie_lie      <= '0;
      mcause_code  <= '0;
      mcause_int   <= 1'b0;
      irq_code     <= '0;
    end
  end

`ifdef SERV_CSR_LIRQ_LATCH_EN
  logic [LW-1:0] lirq_q;
  logic          wr_mip;

  assign wr_mip = i_en & i_csr_sel[2];

  // Rising edge sets the sticky bit; a written 0 clears it unless an edge lands the same cycle.
  always_ff @(posedge i_clk) begin
    lirq_q <= i_lirq;
    for (int unsigned k = 0; k < NIRQ; k++) begin
      if (i_lirq[k] & ~lirq_q[k])
        lirq_pend[k] <= 1'b1;
      else if (wr_mip && slot(i_cnt, 16 + k) && !csr_in[(16 + k) % W])
        lirq_pend[k] <= 1'b0;
    end
    if (RST_EN && i_rst) lirq_pend <= '0;
  end
`else
  assign lirq_pend = i_lirq;
`endif

endmodule

// File: tb/tb_serv_csr_mirq.sv
// Scoreboard bench for serv_csr_mirq: one W=1 and one W=4 instance, exercised in turn.
module tb_serv_csr_mirq;
  logic        clk = 1'b0;
  logic [1:0]  rst = '0, en = '0, done = '0, trig = '0, trap = '0, mret = '0;
  logic [1:0]  probe = '0, rd_active = '0;
  logic [4:0]  cnt [2];
  logic        mtip = 1'b0, meip = 1'b0;
  logic [3:0]  lirq = '0;
  logic        e_op = 1'b0, ebreak = 1'b0, mem_op = 1'b0, mem_cmd = 1'b0;
  logic [3:0]  sel = '0;
  logic [1:0]  src = '0;
  logic        dsel = 1'b0;
  logic [31:0] rs1w = '0, immw = '0;
  logic [31:0] acc [2];

  logic        irq0, irq1, q0, ci0;
  logic [3:0]  q4, ci4;
  logic        rs1_0, imm_0;
  logic [3:0]  rs1_4, imm_4;

  typedef struct { string name; logic [31:0] val; } exp_t;
  exp_t sb [$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rs1_0 = rs1w[cnt[0]];
  assign imm_0 = immw[cnt[0]];
  assign rs1_4 = 4'(rs1w >> cnt[1]);
  assign imm_4 = 4'(immw >> cnt[1]);

  serv_csr_mirq #(.W(1), .NIRQ(4), .RESET_STRATEGY("MINI")) dut1 (
    .i_clk(clk), .i_rst(rst[0]), .i_cnt(cnt[0]), .i_en(en[0]), .i_cnt_done(done[0]),
    .i_trig_irq(trig[0]), .i_mtip(mtip), .i_meip(meip), .i_lirq(lirq), .o_new_irq(irq0),
    .i_trap(trap[0]), .i_mret(mret[0]), .i_e_op(e_op), .i_ebreak(ebreak),
    .i_mem_op(mem_op), .i_mem_cmd(mem_cmd), .i_csr_sel(sel), .i_csr_source(src),
    .i_csr_d_sel(dsel), .i_csr_imm(imm_0), .i_rs1(rs1_0), .i_rf_csr_out(1'b0),
    .o_csr_in(ci0), .o_q(q0));

  serv_csr_mirq #(.W(4), .NIRQ(4), .RESET_STRATEGY("MINI")) dut4 (
    .i_clk(clk), .i_rst(rst[1]), .i_cnt(cnt[1]), .i_en(en[1]), .i_cnt_done(done[1]),
    .i_trig_irq(trig[1]), .i_mtip(mtip), .i_meip(meip), .i_lirq(lirq), .o_new_irq(irq1),
    .i_trap(trap[1]), .i_mret(mret[1]), .i_e_op(e_op), .i_ebreak(ebreak),
    .i_mem_op(mem_op), .i_mem_cmd(mem_cmd), .i_csr_sel(sel), .i_csr_source(src),
    .i_csr_d_sel(dsel), .i_csr_imm(imm_4), .i_rs1(rs1_4), .i_rf_csr_out(4'b0),
    .o_csr_in(ci4), .o_q(q4));

  task automatic compare(input logic [31:0] act);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_output: got %h with no expected entry", act);
    end else begin
      e = sb.pop_front();
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.name, act, e.val);
      end
    end
  endtask

  // Monitor: assembles serial reads and samples probed interrupt state mid-cycle.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      logic [31:0] a;
      if (probe[u]) compare({31'b0, (u == 0) ? irq0 : irq1});
      if (rd_active[u] && en[u]) begin
        a = (cnt[u] == 5'd0) ? 32'd0 : acc[u];
        a = a | (((u == 0) ? 32'(q0) : 32'(q4)) << cnt[u]);
        acc[u] = a;
        if (done[u]) compare(a);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string name, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.val  = v;
    sb.push_back(e);
  endtask

  // Full serial CSR instruction; optional one-cycle lirq pulse at slice pcnt.
  task automatic csr_op(input int u, input logic [3:0] s, input logic [1:0] so,
                        input logic ds, input logic [31:0] word, input logic [31:0] exp_rd,
                        input string name, input int pcnt = -1, input logic [3:0] pmask = '0);
    int wu;
    logic [3:0] saved;
    wu = (u == 0) ? 1 : 4;
    expect_val(name, exp_rd);
    sel = s; src = so; dsel = ds;
    if (ds) begin immw = word; rs1w = ~word; end
    else    begin rs1w = word; immw = ~word; end
    rd_active[u] = 1'b1;
    saved = lirq;
    for (int c = 0; c <= 32 - wu; c += wu) begin
      cnt[u]  = 5'(c);
      en[u]   = 1'b1;
      done[u] = (c == 32 - wu);
      lirq    = (c == pcnt) ? (saved | pmask) : saved;
      cyc();
    end
    lirq = saved;
    en[u] = 1'b0; done[u] = 1'b0; rd_active[u] = 1'b0; cnt[u] = '0;
    sel = '0; src = '0;
  endtask

  task automatic rd(input int u, input logic [3:0] s, input logic [31:0] v, input string name);
    csr_op(u, s, 2'b00, 1'b0, 32'd0, v, name);
  endtask

  task automatic do_reset(input int u);
    rst[u] = 1'b1; cyc(); cyc(); rst[u] = 1'b0;
  endtask

  task automatic do_trig(input int u);
    trig[u] = 1'b1; cyc(); trig[u] = 1'b0;
  endtask

  task automatic do_probe(input int u, input logic v, input string name);
    expect_val(name, {31'b0, v});
    probe[u] = 1'b1; cyc(); probe[u] = 1'b0;
  endtask

  task automatic do_trap(input int u, input logic eo, input logic eb, input logic mo, input logic mc);
    e_op = eo; ebreak = eb; mem_op = mo; mem_cmd = mc;
    trap[u] = 1'b1; done[u] = 1'b1; cyc();
    trap[u] = 1'b0; done[u] = 1'b0;
    e_op = 1'b0; ebreak = 1'b0; mem_op = 1'b0; mem_cmd = 1'b0;
  endtask

  task automatic do_mret(input int u);
    mret[u] = 1'b1; done[u] = 1'b1; cyc(); mret[u] = 1'b0; done[u] = 1'b0;
  endtask

  localparam logic [3:0] MSTATUS = 4'b0001, MIE = 4'b0010, MIP = 4'b0100, MCAUSE = 4'b1000;
  localparam logic [1:0] SCSR = 2'b00, SEXT = 2'b01, SSET = 2'b10, SCLR = 2'b11;

  initial begin
    cnt[0] = '0; cnt[1] = '0;
    acc[0] = '0; acc[1] = '0;
    cyc();

    // W=1 instance
    do_reset(0);
    do_probe(0, 1'b0, "w1_reset_irq");
    rd(0, MSTATUS, 32'h0000_1800, "w1_reset_mstatus");
    rd(0, MIE,     32'h0000_0000, "w1_reset_mie");
    rd(0, MCAUSE,  32'h0000_0000, "w1_reset_mcause");
    rd(0, MIP,     32'h0000_0000, "w1_reset_mip");
    csr_op(0, MSTATUS, SSET, 1'b1, 32'h8,   32'h0000_1800, "w1_csrrsi_mstatus");
    csr_op(0, MIE,     SSET, 1'b0, 32'h800, 32'h0000_0000, "w1_csrrs_mie");
    meip = 1'b1; mtip = 1'b1;
    do_trig(0);
    do_probe(0, 1'b1, "w1_irq_accept");
    rd(0, MIP, 32'h0000_0880, "w1_mip_levels");
    do_trap(0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_probe(0, 1'b0, "w1_irq_cleared_by_trap");
    meip = 1'b0; mtip = 1'b0;
    rd(0, MCAUSE,  32'h8000_000B, "w1_mcause_mei");
    rd(0, MSTATUS, 32'h0000_1880, "w1_mstatus_after_irq_trap");
    do_trap(0, 1'b1, 1'b0, 1'b0, 1'b0);
    rd(0, MCAUSE, 32'h0000_000B, "w1_mcause_ecall");
    do_trap(0, 1'b0, 1'b0, 1'b1, 1'b1);
    rd(0, MCAUSE, 32'h0000_0006, "w1_mcause_store_misaligned");
    do_trap(0, 1'b1, 1'b1, 1'b0, 1'b0);
    rd(0, MCAUSE, 32'h0000_0003, "w1_mcause_ebreak");
    do_trap(0, 1'b0, 1'b0, 1'b1, 1'b0);
    rd(0, MCAUSE, 32'h0000_0004, "w1_mcause_load_misaligned");
    csr_op(0, MCAUSE, SEXT, 1'b0, 32'hFFFF_FFFF, 32'h0000_0004, "w1_mcause_write");
    rd(0, MCAUSE, 32'h8000_001F, "w1_mcause_implemented_bits");
    csr_op(0, MIE, SEXT, 1'b0, 32'h880, 32'h0000_0800, "w1_mie_ext_write");
    rd(0, MIE, 32'h0000_0880, "w1_mie_readback");
    // Reset mid-way through a serial mie write, held across the bit-11 slot
    sel = MIE; src = SEXT; dsel = 1'b0; rs1w = 32'h800;
    for (int c = 0; c <= 11; c++) begin
      cnt[0] = 5'(c); en[0] = 1'b1; rst[0] = (c >= 8);
      cyc();
    end
    rst[0] = 1'b0; en[0] = 1'b0; cnt[0] = '0;
    rd(0, MIE,     32'h0000_0000, "w1_mie_after_midwrite_reset");
    rd(0, MCAUSE,  32'h0000_0000, "w1_mcause_after_reset");
    rd(0, MSTATUS, 32'h0000_1800, "w1_mstatus_after_reset");

    // W=4 instance
    do_reset(1);
    do_probe(1, 1'b0, "w4_reset_irq");
    rd(1, MSTATUS, 32'h0000_1800, "w4_reset_mstatus");
    csr_op(1, MSTATUS, SSET, 1'b0, 32'h8,         32'h0000_1800, "w4_csrrs_mstatus");
    csr_op(1, MIE,     SEXT, 1'b0, 32'h000A_0000, 32'h0000_0000, "w4_mie_write");
    lirq = 4'b1010;
    rd(1, MIP, 32'h000A_0000, "w4_mip_local");
    do_trig(1);
    do_probe(1, 1'b1, "w4_lirq_accept");
    do_trap(1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_probe(1, 1'b0, "w4_irq_cleared_by_trap");
    rd(1, MCAUSE,  32'h8000_0011, "w4_mcause_lirq1");
    rd(1, MSTATUS, 32'h0000_1880, "w4_mstatus_after_trap");
    do_mret(1);
    rd(1, MSTATUS, 32'h0000_1888, "w4_mstatus_after_mret");
    csr_op(1, MIE, SSET, 1'b0, 32'h80, 32'h000A_0000, "w4_mie_set_mtie");
    mtip = 1'b1;
    do_trig(1);
    do_probe(1, 1'b1, "w4_mti_accept");
    do_trap(1, 1'b0, 1'b0, 1'b0, 1'b0);
    mtip = 1'b0;
    rd(1, MCAUSE, 32'h8000_0007, "w4_mcause_mti_over_lirq");
    lirq = 4'b0000;
`ifdef SERV_CSR_LIRQ_LATCH_EN
    rd(1, MIP, 32'h000A_0000, "w4_latch_sticky");
    lirq = 4'b0001; cyc(); lirq = 4'b0000; cyc();
    rd(1, MIP, 32'h000B_0000, "w4_latch_pulse_bit16");
    csr_op(1, MIP, SCLR, 1'b0, 32'h0001_0000, 32'h000B_0000, "w4_latch_csrrc");
    rd(1, MIP, 32'h000A_0000, "w4_latch_cleared_bit16");
    csr_op(1, MIP, SCLR, 1'b0, 32'h0001_0000, 32'h000A_0000, "w4_latch_clr_with_edge",
           16, 4'b0001);
    rd(1, MIP, 32'h000B_0000, "w4_latch_set_wins");
    csr_op(1, MIP, SEXT, 1'b0, 32'h0, 32'h000B_0000, "w4_latch_ext_zero");
    rd(1, MIP, 32'h0000_0000, "w4_latch_all_cleared");
`else
    rd(1, MIP, 32'h0000_0000, "w4_level_mip_idle");
    csr_op(1, MIP, SEXT, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, "w4_level_mip_write");
    rd(1, MIP, 32'h0000_0000, "w4_level_mip_readonly");
    lirq = 4'b0101;
    rd(1, MIP, 32'h0005_0000, "w4_level_mip_follows");
    lirq = 4'b0000;
`endif

    cyc(); cyc();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
